mem_access_unit: RTL and testbench

Load/store execution unit sitting directly downstream of the multicycle control FSM in the RISC-V core. It turns the controller's `MemRead`/`MemWrite` strobes plus `funct3` into a single handshaked transaction on the data-memory bus. It generates byte enables and lane-replicated store data, and returns sign/zero-extended load data. It also detects misaligned and illegal accesses and bus timeouts, and reports each with a one-cycle `done` pulse.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Load/store execution unit placed behind the multicycle control FSM. A rising
// edge on MemRead|MemWrite (seen while idle) starts exactly one transaction on
// the data-memory bus. Byte enables and lane-replicated store data are derived
// from funct3 and addr[1:0]; load data is extracted from the returned word and
// sign/zero-extended. Misaligned/illegal accesses never reach the bus; a bus
// that never acknowledges is abandoned after TIMEOUT request cycles. Every
// accepted request ends with a one-cycle done pulse.
//
// Ports:
//   clock, reset (async, active low)
//   MemRead, MemWrite, funct3, addr, wdata      - request from the controller
//   rdata                                       - extended load result (held)
//   busy, done, err                             - status (err held to next accept)
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata - registered bus request
//   mem_ack, mem_rdata                          - bus response
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_t      state_reg;
    logic        rq_d_reg;
    logic        armed_reg;
    logic        is_load_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  lane_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  err_reg;
    logic        done_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;

    logic        rq;
    logic        accept;
    logic        bad_f3;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign rq = MemRead | MemWrite;

    // armed_reg only becomes 1 once the request level has been seen low after
    // reset, so a level left high across a reset cannot start a transaction.
    assign accept = (state_reg == IDLE) & rq & ~rq_d_reg & armed_reg;

    // Loads allow 000,001,010,100,101; stores only 000..010.
    // MemRead has priority, so it alone decides whether this is a load.
    always_comb begin
        bad_f3 = 1'b0;
        if (MemRead) begin
            bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end else begin
            bad_f3 = funct3[2] || (funct3[1:0] == 2'b11);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = |addr[1:0];
            end
        endcase
    end

    // Lane extraction uses the byte offset latched at accept.
    always_comb begin
        case (lane_reg)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rq_d_reg      <= 1'b0;
            armed_reg     <= 1'b0;
            is_load_reg   <= 1'b0;
            f3_reg        <= 3'd0;
            lane_reg      <= 2'd0;
            cnt_reg       <= 8'd0;
            rdata_reg     <= 32'd0;
            err_reg       <= ERR_OK;
            done_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_be_reg    <= 4'd0;
            mem_wdata_reg <= 32'd0;
        end else begin
            rq_d_reg <= rq;
            if (!rq) begin
                armed_reg <= 1'b1;
            end
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_load_reg <= MemRead;
                        f3_reg      <= funct3;
                        lane_reg    <= addr[1:0];
                        if (bad_f3) begin
                            err_reg   <= ERR_ILLEGAL;
                            done_reg  <= 1'b1;
                            state_reg <= FAULT;
                        end else if (misaligned) begin
                            err_reg   <= ERR_MISALIGN;
                            done_reg  <= 1'b1;
                            state_reg <= FAULT;
                        end else begin
                            err_reg       <= ERR_OK;
                            cnt_reg       <= 8'd0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= ~MemRead;
                            mem_addr_reg  <= {addr[31:2], 2'b00};
                            mem_be_reg    <= be_next;
                            mem_wdata_reg <= wdata_next;
                            state_reg     <= REQ;
                        end
                    end
                end

                REQ: begin
                    // Ack is checked first so it wins over a same-cycle expiry.
                    if (mem_ack) begin
                        if (is_load_reg) begin
                            rdata_reg <= load_ext;
                        end
                        mem_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        err_reg     <= ERR_TIMEOUT;
                        mem_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (TIMEOUT=4). Inputs change and outputs are sampled
// on the falling clock edge. Expected values come from a behavioural model of
// the load/store rules (shifts, multiplies, $signed) and a tracked rdata value.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = 32'd0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // One request: ack_at is the REQ-cycle index (0 = zero-wait) in which the
    // bus acknowledges; any value outside 0..TO-1 means no ack (timeout).
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] md,
                              input int ack_at);
        logic        bad_f3;
        logic        misal;
        logic [1:0]  exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] ext;
        logic [31:0] sh;
        int          req_cycles;

        if (rd) bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        else    bad_f3 = (f3 >= 3'd3);
        misal = 1'b0;
        if (f3[1:0] == 2'd1) misal = (a % 2) != 0;
        if (f3[1:0] == 2'd2) misal = (a % 4) != 0;

        if (f3[1:0] == 2'd0) begin
            exp_be = 4'(1 << (a % 4));
            exp_wd = 32'(wd[7:0]) * 32'h01010101;
            sh     = md >> (8 * (a % 4));
            ext    = f3[2] ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
        end else if (f3[1:0] == 2'd1) begin
            exp_be = ((a % 4) >= 2) ? 4'hC : 4'h3;
            exp_wd = 32'(wd[15:0]) * 32'h00010001;
            sh     = md >> (16 * ((a % 4) / 2));
            ext    = f3[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
        end else begin
            exp_be = 4'hF;
            exp_wd = wd;
            ext    = md;
        end

        @(negedge clock);
        MemRead  = rd;
        MemWrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        mem_ack  = 1'b0;
        @(negedge clock);
        req_cycles = 0;

        if (bad_f3 || misal) begin
            exp_err = bad_f3 ? 2'b10 : 2'b01;
            n_cmp++;
            if (done !== 1'b1 || mem_req !== 1'b0 || err !== exp_err || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s fault: done=%b req=%b err=%b busy=%b, required done=1 req=0 err=%b busy=1",
                         name, done, mem_req, err, busy, exp_err);
            end
        end else begin
            exp_err = 2'b00;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_we !== !rd || mem_addr !== (a & ~32'd3) ||
                mem_be !== exp_be || (!rd && mem_wdata !== exp_wd) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s bus: req=%b we=%b addr=%h be=%b wd=%h, required req=1 we=%b addr=%h be=%b wd=%h",
                         name, mem_req, mem_we, mem_addr, mem_be, mem_wdata, !rd, a & ~32'd3, exp_be, exp_wd);
            end
            for (int c = 0; c < TO; c++) begin
                req_cycles++;
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = md;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                @(negedge clock);
                mem_ack = 1'b0;
                if (c == ack_at || c == TO - 1) begin
                    exp_err = (c == ack_at) ? 2'b00 : 2'b11;
                    if (c == ack_at && rd) exp_rdata = ext;
                    n_cmp++;
                    if (done !== 1'b1 || mem_req !== 1'b0 || err !== exp_err || rdata !== exp_rdata) begin
                        n_bad++;
                        $display("FAIL %s end: done=%b req=%b err=%b rdata=%h, required done=1 req=0 err=%b rdata=%h",
                                 name, done, mem_req, err, rdata, exp_err, exp_rdata);
                    end
                    break;
                end else begin
                    n_cmp++;
                    if (mem_req !== 1'b1 || done !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s wait%0d: req=%b done=%b, required req=1 done=0",
                                 name, c, mem_req, done);
                    end
                end
            end
        end

        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err || rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s idle: done=%b busy=%b err=%b rdata=%h, required done=0 busy=0 err=%b rdata=%h",
                     name, done, busy, err, rdata, exp_err, exp_rdata);
        end
        $display("txn %-10s rd=%b wr=%b f3=%0d addr=%h wd=%h md=%h ack_at=%0d req_cycles=%0d err=%b rdata=%h",
                 name, rd, wr, f3, a, wd, md, ack_at, req_cycles, err, rdata);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (rdata !== 0 || busy !== 0 || done !== 0 || err !== 0 || mem_req !== 0 ||
            mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0) begin
            n_bad++;
            $display("FAIL reset_values: rdata=%h busy=%b done=%b err=%b req=%b we=%b addr=%h be=%b wd=%h, required all 0",
                     rdata, busy, done, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_directed();
        run_access("lw_0x100", 1, 0, 3'b010, 32'h100, 32'h0, 32'h800000F0, 1);
        run_access("lb_0x203", 1, 0, 3'b000, 32'h203, 32'h0, 32'h80123456, 0);
        run_access("lbu_0x203", 1, 0, 3'b100, 32'h203, 32'h0, 32'h80123456, 0);
        run_access("lh_0x102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2);
        run_access("lhu_0x102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0);
        run_access("sh_0x102", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hDEADBEEF, 0);
        run_access("sb_0x101", 0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1);
        run_access("sw_0x40", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0);
        run_access("both_lw", 1, 1, 3'b010, 32'h44, 32'h0, 32'h13572468, 0);
    endtask

    task automatic test_fault();
        run_access("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        run_access("lh_mis", 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        run_access("ld_f3_3", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        run_access("sbu_bad", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        run_access("both_bad", 1, 0, 3'b111, 32'h103, 32'h0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_access("lw_tmo", 1, 0, 3'b010, 32'h200, 32'h0, 32'h11111111, -1);
        run_access("sw_tmo", 0, 1, 3'b010, 32'h204, 32'h22222222, 32'h0, -1);
        run_access("lw_last", 1, 0, 3'b010, 32'h208, 32'h0, 32'h9ABCDEF0, TO - 1);
    endtask

    task automatic test_level_hold();
        int dones;
        dones = 0;
        @(negedge clock);
        MemRead   = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h300;
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
            if (c == 5) MemRead = 1'b0;
        end
        mem_ack   = 1'b0;
        exp_rdata = 32'h12345678;
        n_cmp++;
        if (dones != 1 || rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL level_hold: dones=%0d rdata=%h, required dones=1 rdata=%h", dones, rdata, exp_rdata);
        end
        $display("txn level_hold dones=%0d rdata=%h", dones, rdata);
    endtask

    task automatic test_async_reset();
        int stray;
        stray = 0;
        @(negedge clock);
        MemRead = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h400;
        wdata   = 32'h0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre: req=%b, required 1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        exp_rdata = 32'd0;
        n_cmp++;
        if (mem_req !== 0 || busy !== 0 || done !== 0 || err !== 0 || rdata !== 0 ||
            mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0) begin
            n_bad++;
            $display("FAIL areset_now: req=%b busy=%b done=%b err=%b rdata=%h we=%b addr=%h be=%b wd=%h, required all 0",
                     mem_req, busy, done, err, rdata, mem_we, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL areset_held_level: active cycles=%0d, required 0", stray);
        end
        MemRead = 1'b0;
        $display("txn async_reset stray_cycles=%0d", stray);
        run_access("lw_after", 1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 0);
    endtask

    task automatic test_random();
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          ack_at;
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 2) : 1'b1;
            f3 = 3'($urandom % 8);
            a  = $urandom;
            if ($urandom % 2 == 0) a = a & ~32'd3;
            ack_at = int'($urandom_range(0, 5));
            run_access("random", rd, wr, f3, a, $urandom, $urandom, ack_at);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fault();
        test_timeout();
        test_level_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
